// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the two-requester UART transmit arbiter.
package uart_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    BAUD_CFG,
    START,
    WAIT,
    RELEASE
  } state_t;

  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  localparam int SETTLE_CYCLES_DEF  = 4;
  localparam int TIMEOUT_CYCLES_DEF = 2_000_000;
  localparam int CNT_W              = 21;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter2.sv
// Two-way round-robin picker; the pointer names the requester
// that wins a tie, and the loser of each capture gets it next.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_id = (req == 2'b11) ? ptr_q : (req[1] & ~req[0]);
    gnt    = 2'b00;
    if (|req) gnt = gnt_id ? 2'b10 : 2'b01;
    ptr_d = ptr_q;
    if (upd && (|req)) ptr_d = ~gnt_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between two requesters, reprogramming
// the baud generator only when the granted baud code differs.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_data,
  input  logic [3:0]  req_baud,
  output logic [1:0]  req_ack,
  output logic [1:0]  req_done,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic [1:0]  baud_select,
  output logic        baud_rst_n,
  input  logic        tx_done,
  output logic        timeout_err
);

  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [1:0]       ack_q, ack_d;
  logic [1:0]       done_q, done_d;
  logic             start_q, start_d;
  logic [7:0]       data_q, data_d;
  logic [1:0]       bsel_q, bsel_d;
  logic             brst_n_q, brst_n_d;
  logic             terr_q, terr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gid_q, gid_d;
  logic [1:0]       cbaud_q, cbaud_d;

  logic [1:0] gnt;
  logic       gnt_id;
  logic       arb_upd;

  rr_arbiter2 u_rr (
    .clk    (sys_clk),
    .rst    (reset),
    .req    (req_valid),
    .upd    (arb_upd),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  always_comb begin
    state_d  = state_q;
    ack_d    = 2'b00;
    done_d   = 2'b00;
    start_d  = 1'b0;
    terr_d   = 1'b0;
    data_d   = data_q;
    bsel_d   = bsel_q;
    brst_n_d = 1'b1;
    cnt_d    = cnt_q;
    gid_d    = gid_q;
    cbaud_d  = cbaud_q;
    arb_upd  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d = CAPTURE;
          arb_upd = 1'b1;
          ack_d   = gnt;
          gid_d   = gnt_id;
          data_d  = gnt_id ? req_data[15:8] : req_data[7:0];
          cbaud_d = gnt_id ? req_baud[3:2] : req_baud[1:0];
        end
      end
      CAPTURE: begin
        if (cbaud_q == bsel_q) begin
          state_d = START;
          start_d = 1'b1;
        end else begin
          state_d  = BAUD_CFG;
          bsel_d   = cbaud_q;
          brst_n_d = 1'b0;
          cnt_d    = '0;
        end
      end
      BAUD_CFG: begin
        if (cnt_q == SET_LAST) begin
          state_d = START;
          start_d = 1'b1;
        end else begin
          brst_n_d = 1'b0;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      START: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (tx_done) begin
          state_d = RELEASE;
          done_d  = gid_q ? 2'b10 : 2'b01;
        end else if (cnt_q >= TO_LAST) begin
          state_d = RELEASE;
          done_d  = gid_q ? 2'b10 : 2'b01;
          terr_d  = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ack_q    <= 2'b00;
      done_q   <= 2'b00;
      start_q  <= 1'b0;
      data_q   <= 8'h00;
      bsel_q   <= BAUD_2400;
      brst_n_q <= 1'b0;
      terr_q   <= 1'b0;
      cnt_q    <= '0;
      gid_q    <= 1'b0;
      cbaud_q  <= BAUD_2400;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      start_q  <= start_d;
      data_q   <= data_d;
      bsel_q   <= bsel_d;
      brst_n_q <= brst_n_d;
      terr_q   <= terr_d;
      cnt_q    <= cnt_d;
      gid_q    <= gid_d;
      cbaud_q  <= cbaud_d;
    end
  end

  assign req_ack     = ack_q;
  assign req_done    = done_q;
  assign tx_start    = start_q;
  assign tx_data     = data_q;
  assign baud_select = bsel_q;
  assign baud_rst_n  = brst_n_q;
  assign timeout_err = terr_q;

endmodule
